// File: rtl/pe_int_mac_flex_pkg.sv
// Shared types and constants for the integer MAC processing element.
//   pe_mode_e : PE_MAC accumulates cfg_k beats per result, PE_MUL emits every product.
//   PE_K_W    : width of the beat-count / cfg_k field.
//   PE_DW     : widest operand the pipeline beat record can carry.
//   pe_beat_t : one product travelling down the multiplier pipeline.
package pe_int_mac_flex_pkg;

  typedef enum logic {
    PE_MAC = 1'b0,
    PE_MUL = 1'b1
  } pe_mode_e;

  localparam int PE_K_W = 16;
  localparam int PE_DW  = 16;

  typedef struct packed {
    logic signed [2*PE_DW-1:0] prod;
    logic                      last;
    logic                      first;
  } pe_beat_t;

endpackage

// File: rtl/pe_int_mac_flex_fwd_fifo.sv
// Valid/ready forwarding FIFO with a registered occupancy count.
//   i_push/i_dat   : write side; a push while full is taken only if a pop happens in the same cycle.
//   i_pop          : read strobe, ignored when empty.
//   o_not_full     : space available.
//   o_valid/o_dat  : head of the FIFO.
// DEPTH must be a power of two so the pointers wrap naturally.
module pe_int_mac_flex_fwd_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic         o_not_full,
  output logic         o_valid,
  output logic [W-1:0] o_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_pop      = i_pop & (r_count != '0);
  assign w_push     = i_push & ((r_count != (AW+1)'(DEPTH)) | w_pop);
  assign o_not_full = (r_count != (AW+1)'(DEPTH));
  assign o_valid    = (r_count != '0);
  assign o_dat      = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_dat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pe_int_mac_flex.sv
// Integer systolic-array PE: forwards west->east and north->south through FIFOs,
// multiplies the held row/column operands and accumulates cfg_k products per result.
//   i_row_in_*/o_row_out_* : west input, east forward (valid/ready)
//   i_col_in_*/o_col_out_* : north input, south forward (valid/ready)
//   o_res_*/i_res_ready    : dot-product result stream
//   i_cfg_k                : beats per result, latched on the first beat of a group (0 acts as 1)
//   i_acc_clr              : synchronous abort of holds, pipeline and accumulator
//   o_busy, o_error_bit    : activity flag, sticky overflow flag
// Optional: define PE_STALL_CNT_EN to add o_stall_cnt (cycles with one-sided hold or stall).
// Operand width DW must not exceed PE_DW from the package.
module pe_int_mac_flex
  import pe_int_mac_flex_pkg::*;
#(
  parameter int       DW        = 16,
  parameter int       ACC_W     = 40,
  parameter int       FWD_DEPTH = 4,
  parameter int       MUL_STG   = 2,
  parameter int       SAT       = 1,
  parameter pe_mode_e MODE      = PE_MAC
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_row_in_valid,
  output logic              o_row_in_ready,
  input  logic [DW-1:0]     i_row_in_dat,
  input  logic              i_col_in_valid,
  output logic              o_col_in_ready,
  input  logic [DW-1:0]     i_col_in_dat,
  output logic              o_row_out_valid,
  input  logic              i_row_out_ready,
  output logic [DW-1:0]     o_row_out_dat,
  output logic              o_col_out_valid,
  input  logic              i_col_out_ready,
  output logic [DW-1:0]     o_col_out_dat,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [ACC_W-1:0]  o_res_dat,
  input  logic [PE_K_W-1:0] i_cfg_k,
  input  logic              i_acc_clr,
  output logic              o_busy,
  output logic              o_error_bit
`ifdef PE_STALL_CNT_EN
  ,
  output logic [31:0]       o_stall_cnt
`endif
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic                    w_row_not_full, w_col_not_full;
  logic                    w_row_push, w_col_push;
  logic                    r_a_v, r_b_v;
  logic signed [DW-1:0]    r_a, r_b;
  logic                    w_fire, w_stall;
  logic [PE_K_W-1:0]       r_beat_cnt, r_k, w_k_eff;
  logic                    w_first, w_last;
  logic signed [2*DW-1:0]  w_prod;
  pe_beat_t                r_stg [MUL_STG];
  logic [MUL_STG-1:0]      r_stg_v;
  pe_beat_t                w_fin;
  logic                    w_fin_v;
  logic signed [ACC_W-1:0] r_acc, w_base, w_prod_ext, w_sum, w_acc_next;
  logic                    w_ovf, w_acc_en;
  logic                    r_res_valid;
  logic [ACC_W-1:0]        r_res_dat;
  logic                    r_error;

  // Input side: a beat needs FIFO room and a free (or emptying) hold register.
  assign o_row_in_ready = w_row_not_full & (~r_a_v | w_fire) & ~i_acc_clr;
  assign o_col_in_ready = w_col_not_full & (~r_b_v | w_fire) & ~i_acc_clr;
  assign w_row_push     = i_row_in_valid & o_row_in_ready;
  assign w_col_push     = i_col_in_valid & o_col_in_ready;

  pe_int_mac_flex_fwd_fifo #(.W(DW), .DEPTH(FWD_DEPTH)) u_row_fifo (
    .clk(clk), .nrst(nrst), .i_push(w_row_push), .i_dat(i_row_in_dat), .i_pop(i_row_out_ready),
    .o_not_full(w_row_not_full), .o_valid(o_row_out_valid), .o_dat(o_row_out_dat)
  );

  pe_int_mac_flex_fwd_fifo #(.W(DW), .DEPTH(FWD_DEPTH)) u_col_fifo (
    .clk(clk), .nrst(nrst), .i_push(w_col_push), .i_dat(i_col_in_dat), .i_pop(i_col_out_ready),
    .o_not_full(w_col_not_full), .o_valid(o_col_out_valid), .o_dat(o_col_out_dat)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_a_v <= 1'b0;
      r_b_v <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
    end else if (i_acc_clr) begin
      r_a_v <= 1'b0;
      r_b_v <= 1'b0;
    end else begin
      if (w_row_push) begin
        r_a_v <= 1'b1;
        r_a   <= i_row_in_dat;
      end else if (w_fire) begin
        r_a_v <= 1'b0;
      end
      if (w_col_push) begin
        r_b_v <= 1'b1;
        r_b   <= i_col_in_dat;
      end else if (w_fire) begin
        r_b_v <= 1'b0;
      end
    end
  end

  assign w_fin   = r_stg[MUL_STG-1];
  assign w_fin_v = r_stg_v[MUL_STG-1];
  // Only a finished result that cannot leave blocks the pipe; partial sums never stall.
  assign w_stall = w_fin_v & w_fin.last & r_res_valid & ~i_res_ready;
  assign w_fire  = r_a_v & r_b_v & ~w_stall;

  // cfg_k is only looked at on the first beat; later beats use the latched group length.
  assign w_first = (r_beat_cnt == '0);
  assign w_k_eff = !w_first ? r_k : ((i_cfg_k == '0) ? PE_K_W'(1) : i_cfg_k);
  assign w_last  = (MODE == PE_MUL) | (r_beat_cnt == w_k_eff - 1'b1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_beat_cnt <= '0;
      r_k        <= '0;
    end else if (i_acc_clr) begin
      r_beat_cnt <= '0;
    end else if (w_fire) begin
      if (w_first) r_k <= w_k_eff;
      r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
    end
  end

  assign w_prod = (2*DW)'(r_a) * (2*DW)'(r_b);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_stg_v <= '0;
      for (int i = 0; i < MUL_STG; i++) r_stg[i] <= '0;
    end else if (i_acc_clr) begin
      r_stg_v <= '0;
    end else if (!w_stall) begin
      r_stg_v[0] <= w_fire;
      r_stg[0]   <= '{prod: (2*PE_DW)'(w_prod), last: w_last, first: w_first};
      for (int i = 1; i < MUL_STG; i++) begin
        r_stg_v[i] <= r_stg_v[i-1];
        r_stg[i]   <= r_stg[i-1];
      end
    end
  end

  assign w_prod_ext = ACC_W'($signed(w_fin.prod));
  assign w_base     = w_fin.first ? '0 : r_acc;
  assign w_sum      = w_base + w_prod_ext;
  // Signed overflow: operands agree in sign, sum does not.
  assign w_ovf      = (w_base[ACC_W-1] == w_prod_ext[ACC_W-1]) & (w_sum[ACC_W-1] != w_base[ACC_W-1]);
  assign w_acc_en   = w_fin_v & ~w_stall & ~i_acc_clr;

  always_comb begin
    w_acc_next = w_sum;
    if (w_ovf && (SAT != 0)) w_acc_next = w_base[ACC_W-1] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_acc       <= '0;
      r_res_valid <= 1'b0;
      r_res_dat   <= '0;
      r_error     <= 1'b0;
    end else begin
      if (i_acc_clr) r_acc <= '0;
      else if (w_acc_en) r_acc <= w_fin.last ? '0 : w_acc_next;

      if (w_acc_en && w_fin.last) begin
        r_res_valid <= 1'b1;
        r_res_dat   <= w_acc_next;
      end else if (i_res_ready) begin
        r_res_valid <= 1'b0;
      end

      if (w_acc_en && w_ovf) r_error <= 1'b1;
    end
  end

  assign o_res_valid = r_res_valid;
  assign o_res_dat   = r_res_dat;
  assign o_error_bit = r_error;
  assign o_busy      = r_a_v | r_b_v | (|r_stg_v) | r_res_valid;

`ifdef PE_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_stall_cnt <= '0;
    else if (((r_a_v ^ r_b_v) | w_stall) && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pe_int_mac_flex.sv
module tb_pe_int_mac_flex;
  import pe_int_mac_flex_pkg::*;

  localparam int MUL_STG = 2;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_row_in_valid, o_row_in_ready;
  logic [15:0] i_row_in_dat;
  logic        i_col_in_valid, o_col_in_ready;
  logic [15:0] i_col_in_dat;
  logic        o_row_out_valid, i_row_out_ready;
  logic [15:0] o_row_out_dat;
  logic        o_col_out_valid, i_col_out_ready;
  logic [15:0] o_col_out_dat;
  logic        o_res_valid, i_res_ready;
  logic [31:0] o_res_dat;
  logic [15:0] i_cfg_k;
  logic        i_acc_clr, o_busy, o_error_bit;
`ifdef PE_STALL_CNT_EN
  logic [31:0] o_stall_cnt;
`endif

  pe_int_mac_flex #(
    .DW(16), .ACC_W(32), .FWD_DEPTH(4), .MUL_STG(MUL_STG), .SAT(1), .MODE(PE_MAC)
  ) dut (
    .clk(clk), .nrst(nrst),
    .i_row_in_valid(i_row_in_valid), .o_row_in_ready(o_row_in_ready), .i_row_in_dat(i_row_in_dat),
    .i_col_in_valid(i_col_in_valid), .o_col_in_ready(o_col_in_ready), .i_col_in_dat(i_col_in_dat),
    .o_row_out_valid(o_row_out_valid), .i_row_out_ready(i_row_out_ready), .o_row_out_dat(o_row_out_dat),
    .o_col_out_valid(o_col_out_valid), .i_col_out_ready(i_col_out_ready), .o_col_out_dat(o_col_out_dat),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_dat(o_res_dat),
    .i_cfg_k(i_cfg_k), .i_acc_clr(i_acc_clr), .o_busy(o_busy), .o_error_bit(o_error_bit)
`ifdef PE_STALL_CNT_EN
    , .o_stall_cnt(o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] got[$];
  logic [15:0] rowq[$];
  logic [15:0] colq[$];

  // Handshakes sampled 1 time unit before the rising edge.
  always begin
    @(negedge clk);
    #4;
    if (o_res_valid && i_res_ready) got.push_back(o_res_dat);
    if (o_row_out_valid && i_row_out_ready) rowq.push_back(o_row_out_dat);
    if (o_col_out_valid && i_col_out_ready) colq.push_back(o_col_out_dat);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one beat on both inputs only when both sides can take it, so they stay paired.
  task automatic send_beat(input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    @(negedge clk);
    i_row_in_valid = 1'b0;
    i_col_in_valid = 1'b0;
    while (!(o_row_in_ready && o_col_in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", 64'(o_row_in_ready && o_col_in_ready), 64'(1));
    i_row_in_valid = 1'b1;
    i_col_in_valid = 1'b1;
    i_row_in_dat   = a;
    i_col_in_dat   = b;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    i_row_in_valid = 1'b0;
    i_col_in_valid = 1'b0;
  endtask

  task automatic wait_res(input int cnt);
    int n;
    n = 0;
    while (got.size() < cnt && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("res_count", 64'(got.size()), 64'(cnt));
  endtask

  typedef struct packed {
    logic [15:0]      k;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [31:0]      res;
    logic             err;
  } vec_t;

  function automatic vec_t mk(input int k, input int a0, input int a1, input int a2, input int a3,
                              input int b0, input int b1, input int b2, input int b3,
                              input int res, input bit err);
    vec_t v;
    v.k = 16'(k);
    v.a[0] = 16'(a0); v.a[1] = 16'(a1); v.a[2] = 16'(a2); v.a[3] = 16'(a3);
    v.b[0] = 16'(b0); v.b[1] = 16'(b1); v.b[2] = 16'(b2); v.b[3] = 16'(b3);
    v.res = 32'(res);
    v.err = err;
    return v;
  endfunction

  vec_t        vecs[8];
  int          nb, n;
  bit          ok;
  logic [31:0] r;
  logic [15:0] exp_f[5];

  initial begin
    vecs[0] = mk(4, 1, 2, 3, 4, 2, 2, 2, 2, 20, 1'b0);
    vecs[1] = mk(2, -3, 5, 0, 0, 7, -2, 0, 0, -31, 1'b0);
    vecs[2] = mk(1, 100, 0, 0, 0, -100, 0, 0, 0, -10000, 1'b0);
    vecs[3] = mk(0, 6, 0, 0, 0, 7, 0, 0, 0, 42, 1'b0);
    vecs[4] = mk(3, 32767, -1, 0, 0, 32767, 1, 5, 0, 1073676288, 1'b0);
    vecs[5] = mk(3, -32768, -32768, -32768, 0, -32768, -32768, -32768, 0, 32'h7FFFFFFF, 1'b1);
    vecs[6] = mk(3, -32768, -32768, -32768, 0, 32767, 32767, 32767, 0, 32'h80000000, 1'b1);
    vecs[7] = mk(1, 2, 0, 0, 0, 3, 0, 0, 0, 6, 1'b1);

    nrst = 1'b0;
    i_row_in_valid = 1'b0; i_col_in_valid = 1'b0;
    i_row_in_dat = '0; i_col_in_dat = '0;
    i_row_out_ready = 1'b1; i_col_out_ready = 1'b1; i_res_ready = 1'b1;
    i_cfg_k = 16'd4; i_acc_clr = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_res_valid", 64'(o_res_valid), 64'(0));
    chk("rst_res_dat", 64'(o_res_dat), 64'(0));
    chk("rst_row_out_valid", 64'(o_row_out_valid), 64'(0));
    chk("rst_col_out_valid", 64'(o_col_out_valid), 64'(0));
    chk("rst_row_out_dat", 64'(o_row_out_dat), 64'(0));
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_error_bit", 64'(o_error_bit), 64'(0));
    nrst = 1'b1;
    @(negedge clk);

    // Table-driven dot products, including latency and forwarding order.
    for (int v = 0; v < 8; v++) begin
      nb = (vecs[v].k == 16'd0) ? 1 : int'(vecs[v].k);
      i_cfg_k = vecs[v].k;
      got.delete(); rowq.delete(); colq.delete();
      for (int i = 0; i < nb; i++) send_beat(vecs[v].a[i], vecs[v].b[i]);
      idle();
      n = 1;
      while (!o_res_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      // Result is visible on the falling edge after edge E0+MUL_STG+1.
      chk("res_latency", 64'(n), 64'(MUL_STG + 2));
      wait_res(1);
      r = (got.size() > 0) ? got[0] : 32'hDEAD_0000;
      chk("res_dat", 64'(r), 64'(vecs[v].res));
      chk("error_bit", 64'(o_error_bit), 64'(vecs[v].err));
      ok = (rowq.size() == nb) && (colq.size() == nb);
      if (ok) begin
        for (int i = 0; i < nb; i++)
          if (rowq[i] !== vecs[v].a[i] || colq[i] !== vecs[v].b[i]) ok = 1'b0;
      end
      chk("fwd_order", 64'(ok), 64'(1));
    end

    // Result backpressure: K=1, six beats, result port blocked then released.
    i_cfg_k = 16'd1;
    i_res_ready = 1'b0;
    got.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) send_beat(16'(i + 1), 16'd3);
        idle();
      end
      begin
        repeat (20) @(negedge clk);
        chk("bp_res_valid", 64'(o_res_valid), 64'(1));
        chk("bp_res_dat", 64'(o_res_dat), 64'(3));
        chk("bp_in_ready", 64'(o_row_in_ready), 64'(0));
        chk("bp_busy", 64'(o_busy), 64'(1));
        repeat (3) @(negedge clk);
        chk("bp_res_stable", 64'(o_res_dat), 64'(3));
        i_res_ready = 1'b1;
      end
    join
    wait_res(6);
    for (int i = 0; i < 6; i++) begin
      r = (i < got.size()) ? got[i] : 32'hDEAD_0000;
      chk("bp_res_order", 64'(r), 64'(3 * (i + 1)));
    end

    // East forwarding FIFO full: only one slot opens per pop.
    i_row_out_ready = 1'b0;
    got.delete(); rowq.delete();
    for (int i = 0; i < 4; i++) send_beat(16'(10 + i), 16'd1);
    idle();
    chk("ff_row_ready_full", 64'(o_row_in_ready), 64'(0));
    chk("ff_col_ready", 64'(o_col_in_ready), 64'(1));
    chk("ff_head", 64'(o_row_out_dat), 64'(10));
    i_row_out_ready = 1'b1;
    @(negedge clk);
    i_row_out_ready = 1'b0;
    chk("ff_one_pop", 64'(rowq.size()), 64'(1));
    chk("ff_ready_after_pop", 64'(o_row_in_ready), 64'(1));
    send_beat(16'd99, 16'd1);
    idle();
    chk("ff_full_again", 64'(o_row_in_ready), 64'(0));
    i_row_out_ready = 1'b1;
    repeat (10) @(negedge clk);
    exp_f = '{16'd10, 16'd11, 16'd12, 16'd13, 16'd99};
    ok = (rowq.size() == 5);
    if (ok) for (int i = 0; i < 5; i++) if (rowq[i] !== exp_f[i]) ok = 1'b0;
    chk("ff_order", 64'(ok), 64'(1));
    chk("ff_results", 64'(got.size()), 64'(5));

    // Abort a K=4 group after two beats, then run a clean group of 1x1.
    i_cfg_k = 16'd4;
    got.delete();
    send_beat(16'd5, 16'd5);
    send_beat(16'd5, 16'd5);
    idle();
    i_acc_clr = 1'b1;
    #1;
    chk("clr_in_ready", 64'(o_row_in_ready), 64'(0));
    @(negedge clk);
    i_acc_clr = 1'b0;
    chk("clr_busy", 64'(o_busy), 64'(0));
    for (int i = 0; i < 4; i++) send_beat(16'd1, 16'd1);
    idle();
    wait_res(1);
    r = (got.size() > 0) ? got[0] : 32'hDEAD_0000;
    chk("clr_res_dat", 64'(r), 64'(4));

    // Reset with a result pending and beats in flight.
    i_cfg_k = 16'd1;
    i_res_ready = 1'b0;
    got.delete();
    for (int i = 0; i < 3; i++) send_beat(16'(i + 1), 16'd1);
    idle();
    repeat (3) @(negedge clk);
    chk("pre_rst_res_valid", 64'(o_res_valid), 64'(1));
    nrst = 1'b0;
    #1;
    chk("mid_rst_res_valid", 64'(o_res_valid), 64'(0));
    chk("mid_rst_busy", 64'(o_busy), 64'(0));
    chk("mid_rst_error_bit", 64'(o_error_bit), 64'(0));
    chk("mid_rst_row_out_valid", 64'(o_row_out_valid), 64'(0));
    @(negedge clk);
    nrst = 1'b1;
    i_res_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_no_res", 64'(got.size()), 64'(0));

`ifdef PE_STALL_CNT_EN
    chk("scnt_reset", 64'(o_stall_cnt), 64'(0));
    @(negedge clk);
    i_row_in_valid = 1'b1;
    i_row_in_dat = 16'd7;
    @(posedge clk);
    @(negedge clk);
    i_row_in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("scnt_row_only", 64'(o_stall_cnt), 64'(10));
    i_acc_clr = 1'b1;
    @(negedge clk);
    i_acc_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("scnt_after_clr", 64'(o_stall_cnt), 64'(11));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
